// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// MUL retires mulBits multiplier bits per cycle; DIV is restoring, one bit per cycle.
// Divide-by-zero and signed overflow finish after a single cycle.
// Optional macro MULDIV_EARLY_OUT_EN: MUL stops once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
   parameter int width   = 32,
   parameter int rsWidth = 5,
   parameter int mulBits = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startIn,
   input  logic [2:0]         func3,
   input  logic [width-1:0]   reg1Value,
   input  logic [width-1:0]   reg2Value,
   input  logic [rsWidth-1:0] rd,
   input  logic               killIn,
   input  logic               stallIn,
   output logic               busyOut,
   output logic               doneOut,
   output logic [width-1:0]   resultOut,
   output logic [rsWidth-1:0] rdOut
);

   localparam int CW = $clog2(width) + 1;
   localparam logic [CW-1:0] MUL_ITERS = CW'(width / mulBits);
   localparam logic [CW-1:0] DIV_ITERS = CW'(width);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [2*width-1:0]   prod;
   logic [2*width-1:0]   mcand;
   logic [width-1:0]     mplier;
   logic [width-1:0]     quo;
   logic [width-1:0]     rem;
   logic [width-1:0]     divisor;
   logic [1:0]           op;
   logic                 neg;
   logic                 negRem;
   logic                 spec;
   logic [rsWidth-1:0]   rdq;

   logic                 sgn1, sgn2;
   logic [width-1:0]     mag1, mag2;
   logic                 isSpecial;
   logic [width-1:0]     specVal;
   logic [2*width-1:0]   digit, mulStep, pfin;
   logic [width:0]       divTrial;
   logic                 divGe;
   logic [width:0]       divDiff;
   logic [width-1:0]     qfin, rfin;

   // Operand decode at accept: signedness, magnitudes and one-cycle divide cases.
   always_comb begin
      sgn1 = 1'b0;
      sgn2 = 1'b0;
      case (func3)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            sgn1 = reg1Value[width-1];
            sgn2 = reg2Value[width-1];
         end
         3'd2:    sgn1 = reg1Value[width-1];
         default: ;
      endcase
      mag1 = sgn1 ? -reg1Value : reg1Value;
      mag2 = sgn2 ? -reg2Value : reg2Value;
      isSpecial = 1'b0;
      specVal   = '0;
      if (func3[2]) begin
         if (reg2Value == '0) begin
            isSpecial = 1'b1;
            specVal   = func3[1] ? reg1Value : '1;
         end else if (!func3[0] && reg2Value == '1 &&
                      reg1Value == {1'b1, {(width-1){1'b0}}}) begin
            isSpecial = 1'b1;
            specVal   = func3[1] ? '0 : reg1Value;
         end
      end
   end

   // Iteration datapath and final sign fix-up.
   always_comb begin
      digit    = {{(2*width-mulBits){1'b0}}, mplier[mulBits-1:0]};
      mulStep  = prod + mcand * digit;
      divTrial = {rem, quo[width-1]};
      divGe    = divTrial >= {1'b0, divisor};
      divDiff  = divTrial - {1'b0, divisor};
      pfin     = neg ? -prod : prod;
      qfin     = neg ? -quo : quo;
      rfin     = negRem ? -rem : rem;
   end

   // Control FSM with registered outputs; reset, then kill, take priority.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state     <= IDLE;
         cnt       <= '0;
         prod      <= '0;
         mcand     <= '0;
         mplier    <= '0;
         quo       <= '0;
         rem       <= '0;
         divisor   <= '0;
         op        <= '0;
         neg       <= 1'b0;
         negRem    <= 1'b0;
         spec      <= 1'b0;
         rdq       <= '0;
         busyOut   <= 1'b0;
         doneOut   <= 1'b0;
         resultOut <= '0;
         rdOut     <= '0;
      end else if (killIn) begin
         state   <= IDLE;
         busyOut <= 1'b0;
         doneOut <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (startIn) begin
                  cnt     <= '0;
                  op      <= func3[1:0];
                  rdq     <= rd;
                  neg     <= sgn1 ^ sgn2;
                  negRem  <= sgn1;
                  busyOut <= 1'b1;
                  if (!func3[2]) begin
                     state  <= MUL;
                     prod   <= '0;
                     mcand  <= {{width{1'b0}}, mag1};
                     mplier <= mag2;
                  end else begin
                     // Special cases park their answer in quo and finish on the next edge.
                     state   <= DIV;
                     spec    <= isSpecial;
                     quo     <= isSpecial ? specVal : mag1;
                     rem     <= '0;
                     divisor <= mag2;
                  end
               end
            end
            MUL: begin
               if (cnt == MUL_ITERS) begin
                  state     <= DONE;
                  busyOut   <= 1'b0;
                  doneOut   <= 1'b1;
                  rdOut     <= rdq;
                  resultOut <= (op == 2'd0) ? pfin[width-1:0] : pfin[2*width-1:width];
               end else begin
                  prod   <= mulStep;
                  mcand  <= mcand << mulBits;
                  mplier <= mplier >> mulBits;
`ifdef MULDIV_EARLY_OUT_EN
                  if ((mplier >> mulBits) == '0)
                     cnt <= MUL_ITERS;
                  else
                     cnt <= cnt + CW'(1);
`else
                  cnt    <= cnt + CW'(1);
`endif
               end
            end
            DIV: begin
               if (spec || cnt == DIV_ITERS) begin
                  state     <= DONE;
                  busyOut   <= 1'b0;
                  doneOut   <= 1'b1;
                  rdOut     <= rdq;
                  spec      <= 1'b0;
                  resultOut <= spec ? quo : (op[1] ? rfin : qfin);
               end else begin
                  rem <= divGe ? divDiff[width-1:0] : divTrial[width-1:0];
                  quo <= {quo[width-2:0], divGe};
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (!stallIn) begin
                  state   <= IDLE;
                  doneOut <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit at default parameters.
module tb_ex_muldiv_unit;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startIn;
   logic [2:0]  func3;
   logic [31:0] reg1Value;
   logic [31:0] reg2Value;
   logic [4:0]  rd;
   logic        killIn;
   logic        stallIn;
   logic        busyOut;
   logic        doneOut;
   logic [31:0] resultOut;
   logic [4:0]  rdOut;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.width(32), .rsWidth(5), .mulBits(4)) dut (
      .clk(clk), .resetN(resetN), .startIn(startIn), .func3(func3),
      .reg1Value(reg1Value), .reg2Value(reg2Value), .rd(rd),
      .killIn(killIn), .stallIn(stallIn), .busyOut(busyOut),
      .doneOut(doneOut), .resultOut(resultOut), .rdOut(rdOut)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) begin
`ifdef MULDIV_EARLY_OUT_EN
         logic [31:0] m;
         int bl;
         m  = (f < 3'd2 && b[31]) ? -b : b;
         bl = 0;
         for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
         return ((bl == 0) ? 1 : (bl + 3) / 4) + 1;
`else
         return 9;
`endif
      end
      if (b == 32'h0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input logic [31:0] e, input bit push);
      startIn   = 1'b1;
      func3     = f;
      reg1Value = a;
      reg2Value = b;
      rd        = r;
      if (push) q.push_back('{e, r});
      @(posedge clk);
      @(negedge clk);
      startIn = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int expLat, input bit pulse, output exp_t e);
      int n = 0;
      e = '{32'h0, 5'h0};
      while (!doneOut && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(expLat));
      if (doneOut) begin
         if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
         end else begin
            e = q.pop_front();
            check({tag, "_res"}, 64'(resultOut), 64'(e.res));
            check({tag, "_rd"}, 64'(rdOut), 64'(e.rd));
         end
         if (pulse) begin
            @(negedge clk);
            check({tag, "_pulse"}, 64'(doneOut), 64'(0));
         end
      end
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] r, input logic [31:0] e);
      exp_t got;
      start_op(f, a, b, r, e, 1'b1);
      wait_done(tag, exp_lat(f, a, b), 1'b1, got);
   endtask

   initial begin
      exp_t e;
      bit   saw;
      logic [2:0]  f;
      logic [31:0] a, b;

      resetN = 1'b0; startIn = 1'b0; func3 = 3'd0; reg1Value = '0; reg2Value = '0;
      rd = '0; killIn = 1'b0; stallIn = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busyOut), 64'(0));
      check("rst_done", 64'(doneOut), 64'(0));
      check("rst_res", 64'(resultOut), 64'(0));
      check("rst_rd", 64'(rdOut), 64'(0));
      resetN = 1'b1;
      @(negedge clk);

      run("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
      run("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
      run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
      run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF);
      run("mul0",   3'd0, 32'h1234_5678, 32'd0,         5'd7,  32'h0);
      run("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD);
      run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF);
      run("divu0",  3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF);
      run("remu0",  3'd7, 32'd5,         32'd0,         5'd11, 32'd5);
      run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);
      run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
      run("divuovf",3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0);

      // Kill a DIV at cycle 10, with a competing start in the same cycle.
      start_op(3'd4, 32'd100, 32'd7, 5'd15, 32'h0, 1'b0);
      saw = 1'b0;
      repeat (9) begin
         @(negedge clk);
         saw |= doneOut;
      end
      killIn = 1'b1; startIn = 1'b1; func3 = 3'd0; reg1Value = 32'd3; reg2Value = 32'd3;
      @(negedge clk);
      killIn = 1'b0; startIn = 1'b0;
      check("kill_done", 64'(saw | doneOut), 64'(0));
      check("kill_busy", 64'(busyOut), 64'(0));
      run("after_kill", 3'd5, 32'd100, 32'd7, 5'd16, 32'd14);

      // Stall in DONE for three edges while a new start is offered.
      start_op(3'd0, 32'd12345, 32'd678, 5'd17, 32'd8369910, 1'b1);
      stallIn = 1'b1;
      wait_done("stall", exp_lat(3'd0, 32'd12345, 32'd678), 1'b0, e);
      startIn = 1'b1; func3 = 3'd5; reg1Value = 32'd9; reg2Value = 32'd2; rd = 5'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 1) startIn = 1'b0;
         check("stall_done", 64'(doneOut), 64'(1));
         check("stall_res", 64'(resultOut), 64'(32'd8369910));
         check("stall_rd", 64'(rdOut), 64'(5'd17));
      end
      stallIn = 1'b0;
      @(negedge clk);
      check("stall_release", 64'(doneOut), 64'(0));
      check("stall_nostart", 64'(busyOut), 64'(0));

      // Randomised mix with the reference model.
      for (int i = 0; i < 16; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if (i % 5 == 0) b = 32'($urandom_range(0, 3));
         if (i % 7 == 3) b = b >> 20;
         start_op(f, a, b, 5'(i), ref_res(f, a, b), 1'b1);
         wait_done("rand", exp_lat(f, a, b), 1'b1, e);
      end

      // Reset in the middle of a multiply.
      start_op(3'd0, 32'd99, 32'hFFFF_FFFF, 5'd21, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      check("mrst_busy", 64'(busyOut), 64'(0));
      check("mrst_done", 64'(doneOut), 64'(0));
      check("mrst_res", 64'(resultOut), 64'(0));
      check("mrst_rd", 64'(rdOut), 64'(0));
      resetN = 1'b1;
      @(negedge clk);
      run("post_rst", 3'd7, 32'd100, 32'd7, 5'd22, 32'd2);

      check("sb_left", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
